alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 16-bit CPU ALU. Adds a W-bit datapath, a 4-bit opcode space (carry-chained add/sub, arithmetic shift, rotate, compare), a multi-cycle shift-add multiplier, and an optional restoring divider. Sits in the execute stage between the register file read ports and the writeback mux. The core control unit issues one operation per `start` pulse and stalls on `busy`.

## Interface
- `W`, 16: datapath width (≥4, power of two); shift amount field `SW = $clog2(W)`
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  synchronous reset, active-low (0 = reset)
- `start`  in  1  operation request; accepted only when `busy`=0
- `OPALU`  in  4  opcode, sampled with `start`
- `A`, `B`  in  W  operands, sampled with `start`
- `enFLAGS`  in  1  sampled with `start`; when 1, FLAGS update on completion
- `busy`  out  1  high while a multi-cycle op is in flight
- `done`  out  1  one-cycle pulse; `S`/`R`/FLAGS valid from this cycle
- `S`  out  W  primary result, held until next completion
- `R`  out  W  secondary result (MUL high half, DIV remainder), else 0
- `FLAGS`  out  5  {N,V,C,Z,RUN}: [0] RUN, [1] Z, [2] C, [3] V, [4] N

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 NAND, 6 OR, 7 XOR (0–7 encoding-compatible with the previous ALU), 8 ADC (A+B+C), 9 SBC (A−B−C), A ASR, B ROL, C MUL, D CMP, E DIVU, F MOVB (S=B).
- Shifts and rotates use `B[SW-1:0]` as the amount. C = last bit shifted out. Amount 0 gives S=A, C=0. ROL sets C = new S[0] for amount ≠0.
- ADD/ADC: C = carry out of bit W−1; V = signed overflow (operand signs equal, result sign differs).
- SUB/SBC/CMP: C = borrow (1 when unsigned A < B + Cin); V = signed overflow of A−B. CMP leaves S and R unchanged and updates flags only.
- Logic ops and MOVB: C=0, V=0.
- Z = (S==0) for all ops except CMP, where Z = (A−B==0). N = result MSB.
- MUL: unsigned W×W, S = low half, R = high half. C = (R≠0), V=0, Z from S only.
- DIVU: S = quotient, R = remainder, C=0, V=0.
- Divide by zero: S = all ones, R = A, V=1, C=0, N=1, Z=0.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + `start` + single-cycle op → FIN.
  - IDLE + `start` + MUL → MUL.
  - IDLE + `start` + DIVU (B≠0) → DIV.
  - IDLE + `start` + DIVU (B=0) → FIN.
  - MUL/DIV: iteration counter runs 0..W−1, then → FIN.
  - FIN: registers results, pulses `done`, → IDLE.
- `start` while `busy`=1 is ignored; operands are not re-sampled.
- Reset (rst=0 at a posedge) from any state: state=IDLE, `busy`=0, `done`=0, S=0, R=0, FLAGS=5'b00001, counter=0. An in-flight op is discarded with no `done`.
- FLAGS[0] is written 1 on every flag update. FLAGS hold when `enFLAGS` was 0 at start.
- ADC/SBC use the C flag value present at `start`.

## Timing
- Single-cycle ops: `start` at edge n → `done`=1 and results valid after edge n+1. `busy` stays 0. Back-to-back `start` every other cycle.
- MUL and DIVU (B≠0): `busy`=1 from edge n+1 through edge n+W; `done` after edge n+W+1. Latency W+1 cycles.
- `busy` drops in the same cycle `done` rises. A new `start` is accepted in that cycle.
- `start` in the `done` cycle of a single-cycle op is accepted (state is FIN → IDLE).
- Reset asserted together with `start`: reset wins.

## Configuration
- `ALU_DIV_EN` defined: restoring divider compiled in as above.
- Undefined: no divider logic. DIVU completes in single-cycle latency with S = all ones, R=0, V=1, C=0, N=1, Z=0, regardless of B.

## Test plan
- Reset: hold rst=0 for 2 cycles → S=0, R=0, FLAGS=5'b00001, busy=0, done=0.
- ADD W=16: A=16'h7FFF, B=16'h0001, enFLAGS=1 → done next cycle, S=16'h8000, FLAGS=5'b11001 (N,V,RUN). Then ADC A=16'hFFFF, B=0 with C=0 → S=16'hFFFF.
- SUB/CMP: A=3, B=5 SUB → S=16'hFFFE, C=1, N=1. Then CMP A=5, B=5 → Z=1, S unchanged at 16'hFFFE.
- MUL: A=16'h1234, B=16'h0100 → busy for 16 cycles, done at cycle 17, S=16'h3400, R=16'h0012, C=1. Mid-op `start` is ignored.
- DIVU (macro on): A=100, B=7 → S=14, R=2 at cycle 17. B=0 → S=16'hFFFF, R=100, V=1 after 1 cycle.
- Reset mid-MUL at cycle 5 → no `done` ever, busy=0, FLAGS=5'b00001. Next ADD works normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked W-bit execute-stage ALU with a shift-add multiplier.
// Define ALU_DIV_EN to compile in the restoring unsigned divider.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   OPALU,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         enFLAGS,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic [W-1:0] R,
  output logic [4:0]   FLAGS
);
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SHL = 4'h2, OP_SHR = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_NAND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8, OP_SBC = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC, OP_CMP = 4'hD, OP_DIVU = 4'hE, OP_MOVB = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          en_q, en_d, cin_q, cin_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, hi_q, hi_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W-1:0]  s_q, s_d, r_q, r_d;
  logic [4:0]    flags_q, flags_d;

  logic [SW-1:0]  amt;
  logic [W:0]     cin_ext, add_w, sub_w, shl_w, shr_w, asr_w, mul_sum;
  logic [2*W-1:0] rol_w;
  logic [W-1:0]   res_s, res_r;
  logic           res_n, res_v, res_c, res_z;

  // a_q doubles as multiplier/low product and dividend/quotient; hi_q as high product/remainder
  assign amt     = b_q[SW-1:0];
  assign cin_ext = {{W{1'b0}}, cin_q & ((op_q == OP_ADC) || (op_q == OP_SBC))};
  assign add_w   = {1'b0, a_q} + {1'b0, b_q} + cin_ext;
  assign sub_w   = {1'b0, a_q} - {1'b0, b_q} - cin_ext;
  assign shl_w   = {1'b0, a_q} << amt;
  assign shr_w   = {a_q, 1'b0} >> amt;
  assign asr_w   = $signed({a_q, 1'b0}) >>> amt;
  assign rol_w   = {a_q, a_q} << amt;
  assign mul_sum = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});

`ifdef ALU_DIV_EN
  logic [W:0]   div_rem;
  logic [W-1:0] div_diff;
  logic         div_ge;
  assign div_rem  = {hi_q, a_q[W-1]};
  assign div_ge   = div_rem >= {1'b0, b_q};
  assign div_diff = W'(div_rem - {1'b0, b_q});
`endif

  always_comb begin
    res_s = '0;
    res_r = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        res_s = add_w[W-1:0];
        res_c = add_w[W];
        res_v = (a_q[W-1] == b_q[W-1]) && (add_w[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res_s = sub_w[W-1:0];
        res_c = sub_w[W];
        res_v = (a_q[W-1] != b_q[W-1]) && (sub_w[W-1] != a_q[W-1]);
      end
      OP_SHL:  begin res_s = shl_w[W-1:0]; res_c = shl_w[W]; end
      OP_SHR:  begin res_s = shr_w[W:1];   res_c = shr_w[0]; end
      OP_ASR:  begin res_s = asr_w[W:1];   res_c = asr_w[0]; end
      OP_ROL:  begin res_s = rol_w[2*W-1:W]; res_c = (amt != '0) & rol_w[W]; end
      OP_AND:  res_s = a_q & b_q;
      OP_NAND: res_s = ~(a_q & b_q);
      OP_OR:   res_s = a_q | b_q;
      OP_XOR:  res_s = a_q ^ b_q;
      OP_MOVB: res_s = b_q;
      OP_MUL:  begin res_s = a_q; res_r = hi_q; res_c = |hi_q; end
      OP_DIVU: begin
`ifdef ALU_DIV_EN
        if (b_q == '0) begin
          res_s = '1;
          res_r = a_q;
          res_v = 1'b1;
        end else begin
          res_s = a_q;
          res_r = hi_q;
        end
`else
        res_s = '1;
        res_v = 1'b1;
`endif
      end
      default: res_s = '0;
    endcase
    res_n = res_s[W-1];
    res_z = (res_s == '0);
    // CMP reports flags of A-B but leaves the visible results untouched
    if (op_q == OP_CMP) begin
      res_s = s_q;
      res_r = r_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    en_d    = en_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    busy_d  = (state_q == ST_MUL) || (state_q == ST_DIV);
    done_d  = 1'b0;
    s_d     = s_q;
    r_d     = r_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = OPALU;
          a_d   = A;
          b_d   = B;
          en_d  = enFLAGS;
          cin_d = flags_q[2];
          hi_d  = '0;
          cnt_d = '0;
          if (OPALU == OP_MUL) begin
            state_d = ST_MUL;
`ifdef ALU_DIV_EN
          end else if ((OPALU == OP_DIVU) && (B != '0)) begin
            state_d = ST_DIV;
`endif
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_MUL: begin
        hi_d  = mul_sum[W:1];
        a_d   = {mul_sum[0], a_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(W-1)) state_d = ST_FIN;
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        hi_d  = div_ge ? div_diff : div_rem[W-1:0];
        a_d   = {a_q[W-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(W-1)) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        s_d     = res_s;
        r_d     = res_r;
        if (en_q) flags_d = {res_n, res_v, res_c, res_z, 1'b1};
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      en_q    <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      flags_q <= 5'b00001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      en_q    <= en_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      r_q     <= r_d;
      flags_q <= flags_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign R     = r_q;
  assign FLAGS = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq at W=16, honours ALU_DIV_EN.
module tb_alu_seq;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  OPALU = 4'h0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic        enFLAGS = 1'b0;
  logic        busy, done;
  logic [15:0] S, R;
  logic [4:0]  FLAGS;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .OPALU(OPALU), .A(A), .B(B),
    .enFLAGS(enFLAGS), .busy(busy), .done(done), .S(S), .R(R), .FLAGS(FLAGS)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    logic [3:0]  op;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_s = 16'h0;
  logic [15:0] m_r = 16'h0;
  logic [4:0]  m_f = 5'b00001;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_s = 16'h0;
    m_r = 16'h0;
    m_f = 5'b00001;
  endfunction

  // Reference behaviour from the opcode rules, using integer arithmetic
  function automatic void model_apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic en);
    int ua, ub, sa, sbv, amt, full, sres, cin;
    longint p;
    logic [31:0] t;
    logic [63:0] pw;
    logic [15:0] ns, nr;
    logic n, v, c, z;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    amt = ub % 16;
    cin = ((op == 4'h8 || op == 4'h9) && m_f[2]) ? 1 : 0;
    ns = 16'h0; nr = 16'h0; c = 1'b0; v = 1'b0; t = 32'h0;
    case (op)
      4'h0, 4'h8: begin
        full = ua + ub + cin; t = full; ns = t[15:0];
        c = (full > 65535);
        sres = sa + sbv + cin; v = (sres > 32767) || (sres < -32768);
      end
      4'h1, 4'h9, 4'hD: begin
        full = ua - ub - cin; t = full; ns = t[15:0];
        c = (full < 0);
        sres = sa - sbv - cin; v = (sres > 32767) || (sres < -32768);
      end
      4'h2: begin t = ua << amt; ns = t[15:0]; c = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0); end
      4'h3: begin t = ua >> amt; ns = t[15:0]; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'hA: begin t = sa >>> amt; ns = t[15:0]; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'hB: begin t = (ua << amt) | (ua >> (16 - amt)); ns = t[15:0]; c = (amt != 0) && ns[0]; end
      4'h4: ns = a & b;
      4'h5: ns = ~(a & b);
      4'h6: ns = a | b;
      4'h7: ns = a ^ b;
      4'hF: ns = b;
      4'hC: begin
        p = longint'(ua) * longint'(ub); pw = p;
        ns = pw[15:0]; nr = pw[31:16]; c = (nr != 0);
      end
      4'hE: begin
`ifdef ALU_DIV_EN
        if (ub == 0) begin ns = 16'hFFFF; nr = a; v = 1'b1; end
        else begin t = ua / ub; ns = t[15:0]; t = ua % ub; nr = t[15:0]; end
`else
        ns = 16'hFFFF; nr = 16'h0; v = 1'b1;
`endif
      end
      default: ns = 16'h0;
    endcase
    n = ns[15];
    z = (ns == 16'h0);
    if (op == 4'hD) begin
      n = t[15]; z = (t[15:0] == 16'h0); ns = m_s; nr = m_r;
    end
    m_s = ns;
    m_r = nr;
    if (en) m_f = {n, v, c, z, 1'b1};
  endfunction

  // Monitor: pops expected response whenever the DUT signals completion
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        $display("TXN op=%h S=%h R=%h FLAGS=%b cyc=%0d (exp S=%h R=%h FLAGS=%b cyc=%0d)",
                 e.op, S, R, FLAGS, cyc, e.s, e.r, e.f, e.exp_cyc);
        check("S", 32'(S), 32'(e.s));
        check("R", 32'(R), 32'(e.r));
        check("FLAGS", 32'(FLAGS), 32'(e.f));
        check("latency", 32'(cyc), 32'(e.exp_cyc));
        check("busy_at_done", 32'(busy), 32'h0);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_S"}, 32'(S), 32'h0);
    check({tag, "_R"}, 32'(R), 32'h0);
    check({tag, "_FLAGS"}, 32'(FLAGS), 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after a reset)
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic en, input int mid_at, input int rst_at);
    exp_t e;
    int n, busy_cnt;
    bit multi;
    multi = (op == 4'hC);
`ifdef ALU_DIV_EN
    if (op == 4'hE && b != 16'h0) multi = 1'b1;
`endif
    start = 1'b1; OPALU = op; A = a; B = b; enFLAGS = en;
    model_apply(op, a, b, en);
    e.s = m_s; e.r = m_r; e.f = m_f; e.op = op;
    e.exp_cyc = cyc + 1 + (multi ? W + 1 : 1);
    sb.push_back(e);
    @(negedge clk);
    OPALU = 4'($urandom); A = 16'($urandom); B = 16'($urandom); enFLAGS = 1'($urandom);
    n = 1; busy_cnt = 0;
    while (!done && n < 4 * W) begin
      if (busy) busy_cnt++;
      if (n == rst_at) begin
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        model_reset();
        return;
      end
      start = (n == mid_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'h1);
    check("busy_cycles", 32'(busy_cnt), multi ? 32'(W) : 32'h0);
    if (!done) sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    int mid;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    run_op(4'h0, 16'h7FFF, 16'h0001, 1'b1, -1, -1);
    run_op(4'h8, 16'hFFFF, 16'h0000, 1'b1, -1, -1);
    run_op(4'h1, 16'h0003, 16'h0005, 1'b1, -1, -1);
    run_op(4'hD, 16'h0005, 16'h0005, 1'b1, -1, -1);
    run_op(4'hC, 16'h1234, 16'h0100, 1'b1, 3, -1);
    run_op(4'hE, 16'd100, 16'd7, 1'b1, -1, -1);
    run_op(4'hE, 16'd100, 16'd0, 1'b1, -1, -1);
    run_op(4'hB, 16'h8001, 16'h0001, 1'b1, -1, -1);
    run_op(4'hA, 16'h8000, 16'h000F, 1'b1, -1, -1);
    run_op(4'h2, 16'hABCD, 16'h0000, 1'b1, -1, -1);

    run_op(4'hC, 16'h1234, 16'h5678, 1'b1, -1, 5);
    repeat (3) @(negedge clk);
    check_reset_state("mid_mul_reset");
    run_op(4'h0, 16'h1111, 16'h2222, 1'b1, -1, -1);

    start = 1'b1; rst = 1'b0; OPALU = 4'h0; A = 16'h0005; B = 16'h0006; enFLAGS = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset_with_start");

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 17));
        1: b = 16'h0;
        default: b = 16'($urandom);
      endcase
      mid = (op == 4'hC && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, W)) : -1;
      run_op(op, a, b, 1'($urandom_range(0, 3) != 0), mid, -1);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
